load_store_unit: RTL

Memory-access stage placed directly downstream of the ALU in the single-cycle RV32I core. It uses `ALUResult` as the effective address and `ReadData2` as store data, and runs byte/half/word loads and stores against a valid/ready data-memory port. It stalls the core until the access completes, and returns sign- or zero-extended `LoadData` to the write-back mux. Misaligned, illegal and timed-out accesses end as a one-cycle fault instead of a memory transaction.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_mem_if.sv | 20 ++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    localparam int CNT_W = 16;

    function automatic logic f3_legal(logic [2:0] f3, logic store);
        if (store)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Valid/ready data-memory port between the LSU and memory.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering, load extension and request legality checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_chk_f3,
    input  logic [1:0]  i_chk_lsb,
    input  logic        i_chk_store,
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_wd,
    input  logic [31:0] i_rdata,
    output logic        o_illegal,
    output logic        o_misal,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Checks look at the live request; steering uses the latched one.
    always_comb begin
        o_illegal = !f3_legal(i_chk_f3, i_chk_store);
        o_misal   = 1'b0;
        unique case (1'b1)
            (i_chk_f3 == F3_H),
            (i_chk_f3 == F3_HU): o_misal = i_chk_lsb[0];
            (i_chk_f3 == F3_W):  o_misal = |i_chk_lsb;
            default:             o_misal = 1'b0;
        endcase
    end

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wd;
        unique case (1'b1)
            (i_f3[1:0] == 2'b00): begin
                o_wstrb = 4'b0001 << i_lsb;
                o_wdata = {4{i_wd[7:0]}};
            end
            (i_f3[1:0] == 2'b01): begin
                o_wstrb = i_lsb[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wd[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        unique case (i_lsb)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half  = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ldata = i_rdata;
        unique case (1'b1)
            (i_f3 == F3_B):  o_ldata = {{24{w_byte[7]}}, w_byte};
            (i_f3 == F3_BU): o_ldata = {24'd0, w_byte};
            (i_f3 == F3_H):  o_ldata = {{16{w_half[15]}}, w_half};
            (i_f3 == F3_HU): o_ldata = {16'd0, w_half};
            default:         o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: aligned B/H/W loads and stores over a valid/ready port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    lsu_mem_if.master   mem,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        Fault,
    output logic [1:0]  FaultCause
);

    localparam logic [CNT_W:0] LP_TO = (CNT_W+1)'(TIMEOUT_CYCLES);

    lsu_state_t       r_state;
    lsu_state_t       w_next;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [2:0]       r_f3;
    logic [31:0]      r_wd;
    logic [31:0]      r_ld;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_cnt;

    logic        w_req;
    logic        w_illegal;
    logic        w_misal;
    logic        w_to_hit;
    logic        w_latch;
    logic        w_ld_we;
    logic        w_cause_we;
    logic [1:0]  w_cause_nx;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    assign w_req    = MemRead | MemWrite;
    assign w_to_hit = (LP_TO != '0) && (({1'b0, r_cnt} + 1'b1) == LP_TO);

    lsu_align u_align (
        .i_chk_f3   (funct3),
        .i_chk_lsb  (ALUResult[1:0]),
        .i_chk_store(MemWrite),
        .i_f3       (r_f3),
        .i_lsb      (r_addr[1:0]),
        .i_wd       (r_wd),
        .i_rdata    (mem.mem_rdata),
        .o_illegal  (w_illegal),
        .o_misal    (w_misal),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_ld_we    = 1'b0;
        w_cause_we = 1'b0;
        w_cause_nx = r_cause;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_illegal || (MemRead && MemWrite)) begin
                        w_next     = S_FAULT;
                        w_cause_we = 1'b1;
                        w_cause_nx = FC_ILLEGAL;
                    end else if (w_misal) begin
                        w_next     = S_FAULT;
                        w_cause_we = 1'b1;
                        w_cause_nx = FC_MISALIGN;
                    end else begin
                        w_next  = S_REQ;
                        w_latch = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ready) begin
                    w_next  = S_DONE;
                    w_ld_we = !r_we;
                end else if (w_to_hit) begin
                    w_next     = S_FAULT;
                    w_cause_we = 1'b1;
                    w_cause_nx = FC_TIMEOUT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_wd    <= '0;
            r_ld    <= '0;
            r_cause <= FC_NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr <= ALUResult;
                r_we   <= MemWrite;
                r_f3   <= funct3;
                r_wd   <= ReadData2;
                r_cnt  <= '0;
            end else if (r_state == S_REQ && !mem.mem_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_ld_we)
                r_ld <= w_ldata;
            if (w_cause_we)
                r_cause <= w_cause_nx;
        end
    end

    assign mem.mem_req   = (r_state == S_REQ);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata = w_wdata;
    assign mem.mem_wstrb = r_we ? w_wstrb : 4'b0000;

    // Gated by rst_n so a reset during an access releases the core at once.
    assign Stall = rst_n &&
                   (((r_state == S_IDLE) && w_req) || (r_state == S_REQ));

    assign Done       = (r_state == S_DONE);
    assign Fault      = (r_state == S_FAULT);
    assign LoadData   = r_ld;
    assign FaultCause = r_cause;

endmodule
